// File: rtl/ramb4_s2_rd_pkg.sv
// Shared types and constants for the RAMB4_S2 stream reader.
package ramb4_s2_rd_pkg;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 2;
  localparam int unsigned LANES     = 4;
  localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

  // Word counts beyond the RAM depth would re-read the same words; cap at one full pass.
  function automatic int unsigned clamp_len(input int unsigned len);
    return (len > RAM_DEPTH) ? RAM_DEPTH : len;
  endfunction

endpackage

// File: rtl/ramb_lane_packer.sv
// Packs captured RAM words into beats and holds each beat on a valid/ready port.
module ramb_lane_packer #(
  parameter int unsigned DATA_W = ramb4_s2_rd_pkg::DATA_W,
  parameter int unsigned LANES  = ramb4_s2_rd_pkg::LANES
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cap_vld,
  input  logic                    i_cap_last,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_ready,
  output logic [DATA_W*LANES-1:0] o_data,
  output logic [LANES-1:0]        o_keep,
  output logic                    o_last,
  output logic                    o_valid,
  output logic                    o_loading
);
  import ramb4_s2_rd_pkg::*;

  localparam int unsigned LANE_W = $clog2(LANES);

  logic [LANE_W-1:0]       r_lane;
  logic [DATA_W*LANES-1:0] r_lanes;
  logic [DATA_W*LANES-1:0] r_out_data;
  logic [LANES-1:0]        r_out_keep;
  logic                    r_out_last;
  logic                    r_out_valid;

  logic                    w_complete;
  logic [DATA_W*LANES-1:0] w_beat;
  logic [LANES-1:0]        w_keep;

  // Merge the incoming word into its lane and derive the filled-lane mask.
  always_comb begin
    w_complete = i_cap_vld && ((r_lane == '1) || i_cap_last);
    w_beat     = r_lanes;
    w_beat[r_lane*DATA_W +: DATA_W] = i_data;
    w_keep     = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (LANE_W'(k) <= r_lane) w_keep[k] = 1'b1;
    end
  end

  // Lane accumulator: lanes restart cleared so a partial final beat has zero upper lanes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lane  <= '0;
      r_lanes <= '0;
    end else if (i_cap_vld) begin
      if (w_complete) begin
        r_lane  <= '0;
        r_lanes <= '0;
      end else begin
        r_lane  <= r_lane + LANE_W'(1);
        r_lanes <= w_beat;
      end
    end
  end

  // Output holding register: loads a completed beat, otherwise holds until accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_complete) begin
      r_out_data  <= w_beat;
      r_out_keep  <= w_keep;
      r_out_last  <= i_cap_last;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && i_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_data    = r_out_data;
  assign o_keep    = r_out_keep;
  assign o_last    = r_out_last;
  assign o_valid   = r_out_valid;
  assign o_loading = w_complete;

endmodule

// File: rtl/ramb4_s2_stream_reader.sv
// Sequential block-RAM reader that streams packed 4-word beats with backpressure.
module ramb4_s2_stream_reader #(
  parameter int unsigned ADDR_W = ramb4_s2_rd_pkg::ADDR_W,
  parameter int unsigned DATA_W = ramb4_s2_rd_pkg::DATA_W,
  parameter int unsigned LANES  = ramb4_s2_rd_pkg::LANES,
  parameter int unsigned LEN_W  = 12
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic [ADDR_W-1:0]       BASE_ADDR,
  input  logic [LEN_W-1:0]        LEN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [ADDR_W-1:0]       RAM_ADDR,
  output logic                    RAM_EN,
  output logic                    RAM_WE,
  output logic                    RAM_RST,
  input  logic [DATA_W-1:0]       RAM_DO,
  output logic [DATA_W*LANES-1:0] M_DATA,
  output logic [LANES-1:0]        M_KEEP,
  output logic                    M_LAST,
  output logic                    M_VALID,
  input  logic                    M_READY
);
  import ramb4_s2_rd_pkg::*;

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned LANE_W = $clog2(LANES);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_issued;
  logic              r_cap_vld;
  logic              r_cap_last;

  logic [CNT_W-1:0]  w_len_clamped;
  logic              w_final_word;
  logic              w_beat_end;
  logic              w_out_free;
  logic              w_issue;
  logic              w_loading;
  logic              w_last_hs;

  // Issue gating. A beat-completing read lands in the output register one cycle
  // later, so the register must be free by then. A beat loading this cycle
  // (lane-3 read followed directly by a lone final word) also blocks the issue,
  // otherwise that final word could overwrite an unaccepted beat.
  always_comb begin
    w_len_clamped = CNT_W'(clamp_len(32'(LEN)));
    w_final_word  = (r_issued == r_len - CNT_W'(1));
    w_beat_end    = (r_issued[LANE_W-1:0] == '1) || w_final_word;
    w_out_free    = (!M_VALID || M_READY) && !w_loading;
    w_issue       = (r_state == READ) && (!w_beat_end || w_out_free);
    w_last_hs     = M_VALID && M_READY && M_LAST;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (START) w_state_nxt = (w_len_clamped == '0) ? FIN : READ;
      READ:  if (w_issue && w_final_word) w_state_nxt = DRAIN;
      DRAIN: if (w_last_hs) w_state_nxt = FIN;
      FIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Command latch, word-issue counter and read-return tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_last <= 1'b0;
    end else begin
      if (r_state == IDLE && START) begin
        r_base   <= BASE_ADDR;
        r_len    <= w_len_clamped;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + CNT_W'(1);
      end
      r_cap_vld  <= w_issue;
      r_cap_last <= w_issue && w_final_word;
    end
  end

  // Output decode.
  always_comb begin
    BUSY     = (r_state == READ) || (r_state == DRAIN);
    DONE     = (r_state == FIN);
    RAM_EN   = w_issue;
    RAM_ADDR = (r_state == READ) ? (r_base + r_issued[ADDR_W-1:0]) : '0;
    RAM_WE   = 1'b0;
    RAM_RST  = 1'b0;
  end

  ramb_lane_packer #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) u_packer (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_cap_vld  (r_cap_vld),
    .i_cap_last (r_cap_last),
    .i_data     (RAM_DO),
    .i_ready    (M_READY),
    .o_data     (M_DATA),
    .o_keep     (M_KEEP),
    .o_last     (M_LAST),
    .o_valid    (M_VALID),
    .o_loading  (w_loading)
  );

endmodule

// File: tb/tb_ramb4_s2_stream_reader.sv
// Testbench for ramb4_s2_stream_reader with a behavioural 2048x2 synchronous RAM.
module tb_ramb4_s2_stream_reader;

  logic        CLK = 1'b0;
  logic        RST, START, M_READY;
  logic [10:0] BASE_ADDR;
  logic [11:0] LEN;
  logic        BUSY, DONE, RAM_EN, RAM_WE, RAM_RST, M_LAST, M_VALID;
  logic [10:0] RAM_ADDR;
  logic [1:0]  RAM_DO = 2'b00;
  logic [7:0]  M_DATA;
  logic [3:0]  M_KEEP;

  always #5 CLK = ~CLK;

  ramb4_s2_stream_reader #(
    .ADDR_W (11),
    .DATA_W (2),
    .LANES  (4),
    .LEN_W  (12)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .BASE_ADDR (BASE_ADDR),
    .LEN       (LEN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .RAM_ADDR  (RAM_ADDR),
    .RAM_EN    (RAM_EN),
    .RAM_WE    (RAM_WE),
    .RAM_RST   (RAM_RST),
    .RAM_DO    (RAM_DO),
    .M_DATA    (M_DATA),
    .M_KEEP    (M_KEEP),
    .M_LAST    (M_LAST),
    .M_VALID   (M_VALID),
    .M_READY   (M_READY)
  );

  // Behavioural RAM: one-cycle synchronous read.
  logic [1:0] mem [0:2047];
  always @(posedge CLK) if (RAM_EN) RAM_DO <= mem[RAM_ADDR];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor state (sampled on the falling edge).
  int          s_cyc = 0;
  logic [10:0] addr_q[$];
  int          en_rel_q[$];
  logic [7:0]  dat_q[$];
  logic [3:0]  keep_q[$];
  logic        last_q[$];
  int          hs_q[$];
  int          done_q[$];
  int          first_valid = -1;
  int          busy_cnt = 0;
  int          hold_viol = 0;
  int          tie_viol = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_dat;
  logic [3:0]  prev_keep;
  logic        prev_last;

  always @(negedge CLK) begin
    if (RAM_EN) begin
      addr_q.push_back(RAM_ADDR);
      en_rel_q.push_back(cyc - s_cyc);
    end
    if (M_VALID && first_valid < 0) first_valid = cyc - s_cyc;
    if (prev_stall && !(M_VALID && M_DATA == prev_dat && M_KEEP == prev_keep && M_LAST == prev_last))
      hold_viol++;
    prev_stall = M_VALID && !M_READY;
    prev_dat   = M_DATA;
    prev_keep  = M_KEEP;
    prev_last  = M_LAST;
    if (M_VALID && M_READY) begin
      dat_q.push_back(M_DATA);
      keep_q.push_back(M_KEEP);
      last_q.push_back(M_LAST);
      hs_q.push_back(cyc - s_cyc);
    end
    if (DONE) done_q.push_back(cyc - s_cyc);
    if (BUSY) busy_cnt++;
    if (RAM_WE || RAM_RST) tie_viol++;
  end

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_mon();
    addr_q.delete(); en_rel_q.delete(); dat_q.delete(); keep_q.delete();
    last_q.delete(); hs_q.delete(); done_q.delete();
    first_valid = -1; busy_cnt = 0; hold_viol = 0; prev_stall = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic [10:0] base;
    logic [11:0] len;
    int          stall_lo;
    int          stall_hi;
    int          xstart_rel;
    int          exp_beats;
    int          exp_first_valid;
    logic [3:0]  exp_last_keep;
  } vec_t;

  vec_t vecs[7];

  // Runs one command, then compares everything observed against a word-level model.
  task automatic run_vec(input vec_t v, input int idx);
    int n, t, rel, bad, last_hs;
    logic [7:0] ed;
    logic [3:0] ek;
    clear_mon();
    step();
    s_cyc = cyc;
    START = 1'b1; BASE_ADDR = v.base; LEN = v.len; M_READY = 1'b1;
    t = 0;
    while (done_q.size() == 0 && t < 6000) begin
      step(); t++;
      rel = cyc - s_cyc;
      START     = (rel == v.xstart_rel);
      BASE_ADDR = (rel == v.xstart_rel) ? ~v.base : v.base;
      LEN       = (rel == v.xstart_rel) ? 12'd7 : v.len;
      M_READY   = !(rel >= v.stall_lo && rel <= v.stall_hi);
    end
    START = 1'b0; M_READY = 1'b1;
    repeat (4) step();

    n = (v.len > 12'd2048) ? 2048 : int'(v.len);
    last_hs = (hs_q.size() > 0) ? hs_q[$] : -100;
    chk($sformatf("v%0d done_count", idx), done_q.size(), 1);
    if (done_q.size() > 0) chk($sformatf("v%0d done_after_last_hs", idx), done_q[0], last_hs + 1);
    chk($sformatf("v%0d beats", idx), dat_q.size(), v.exp_beats);
    chk($sformatf("v%0d first_valid", idx), first_valid, v.exp_first_valid);
    chk($sformatf("v%0d ram_en_count", idx), addr_q.size(), n);
    bad = 0;
    foreach (addr_q[i]) if (addr_q[i] != 11'(v.base + i)) bad++;
    chk($sformatf("v%0d addr_seq_errors", idx), bad, 0);
    bad = 0;
    for (int b = 0; b < dat_q.size() && b < v.exp_beats; b++) begin
      ed = '0; ek = '0;
      for (int k = 0; k < 4; k++) begin
        if (4*b + k < n) begin
          ed = ed | (8'(mem[11'(v.base + 4*b + k)]) << (2*k));
          ek[k] = 1'b1;
        end
      end
      if (dat_q[b] != ed || keep_q[b] != ek || last_q[b] != (b == v.exp_beats - 1)) bad++;
    end
    chk($sformatf("v%0d beat_errors", idx), bad, 0);
    if (keep_q.size() > 0) chk($sformatf("v%0d last_keep", idx), keep_q[$], v.exp_last_keep);
    chk($sformatf("v%0d hold_violations", idx), hold_viol, 0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 2'((i * 7) ^ (i >> 3));
    mem[11'h010] = 2'd0; mem[11'h011] = 2'd1; mem[11'h012] = 2'd2; mem[11'h013] = 2'd3;
    mem[11'h014] = 2'd3; mem[11'h015] = 2'd2; mem[11'h016] = 2'd1; mem[11'h017] = 2'd0;

    //          base     len       stall     xstart beats fv  last_keep
    vecs[0] = '{11'h010, 12'd8,    -1, -1,   -1,    2,   6,  4'hF};
    vecs[1] = '{11'h010, 12'd8,     5, 15,   -1,    2,   6,  4'hF};
    vecs[2] = '{11'h7FE, 12'd5,    -1, -1,   -1,    2,   6,  4'h1};
    vecs[3] = '{11'h123, 12'd3,    -1, -1,   -1,    1,   5,  4'h7};
    vecs[4] = '{11'h5A0, 12'd13,    7,  9,    3,    4,   6,  4'h1};
    vecs[5] = '{11'h3FF, 12'd4095, -1, -1,   -1,  512,   6,  4'hF};
    vecs[6] = '{11'h700, 12'd2048, 20, 60,  100,  512,   6,  4'hF};

    RST = 1'b1; START = 1'b0; M_READY = 1'b1; BASE_ADDR = '0; LEN = '0;
    repeat (3) step();
    @(negedge CLK);
    chk("reset_outputs", {BUSY, DONE, RAM_EN, RAM_ADDR, M_VALID, M_DATA, M_KEEP, M_LAST}, '0);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        if (dat_q.size() == 2) begin
          chk("v0 beat0", dat_q[0], 8'hE4);
          chk("v0 beat1", dat_q[1], 8'h1B);
          chk("v0 last_flags", {last_q[0], last_q[1]}, 2'b01);
        end
        if (done_q.size() > 0) chk("v0 done_rel", done_q[0], 11);
      end
      if (i == 1) begin
        if (en_rel_q.size() == 8) chk("v1 read_0x017_rel", en_rel_q[7], 16);
        if (dat_q.size() == 2) chk("v1 beats", {dat_q[0], dat_q[1]}, 16'hE41B);
        if (done_q.size() > 0) chk("v1 done_rel", done_q[0], 19);
      end
      if (i == 2 && addr_q.size() == 5)
        chk("v2 wrap_addrs", {addr_q[0], addr_q[1], addr_q[2], addr_q[3], addr_q[4]},
            {11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002});
    end

    // Zero-length command: straight to completion, no reads, no beats, never busy.
    clear_mon();
    step();
    s_cyc = cyc; START = 1'b1; BASE_ADDR = 11'h055; LEN = 12'd0;
    step(); START = 1'b0;
    repeat (6) step();
    chk("len0 ram_en", addr_q.size(), 0);
    chk("len0 beats", dat_q.size(), 0);
    chk("len0 busy", busy_cnt, 0);
    chk("len0 done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("len0 done_within_2", (done_q[0] >= 1 && done_q[0] <= 2), 1'b1);

    // Reset in the middle of a command aborts it without DONE.
    clear_mon();
    step();
    s_cyc = cyc; START = 1'b1; BASE_ADDR = 11'h010; LEN = 12'd8;
    step(); START = 1'b0;
    repeat (3) step();
    chk("abort busy_before_rst", BUSY, 1'b1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("abort outputs_after_rst", {BUSY, DONE, RAM_EN, RAM_ADDR, M_VALID, M_DATA, M_KEEP, M_LAST}, '0);
    repeat (10) step();
    chk("abort no_done", done_q.size(), 0);
    chk("abort no_beats", dat_q.size(), 0);
    run_vec(vecs[0], 7);

    chk("ram_we_rst_tied_low", tie_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
